// File: rtl/fastclk_sel_ctrl.sv
// Fast-clock mux controller: divides clk into fast_clk_div, qualifies fast_clk_ext by
// per-window edge counts, and moves fast_clk_sel only on a falling edge of fast_clk_div.
module fastclk_sel_ctrl #(
  parameter int WINDOW       = 1000,
  parameter int MIN_EDGES    = 120,
  parameter int MAX_EDGES    = 143,
  parameter int GOOD_WINDOWS = 4,
  parameter int DIV          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fast_clk_ext,
  input  logic        force_div,
  output logic        fast_clk_div,
  output logic        fast_clk_sel,
  output logic        ext_ok,
  output logic [15:0] last_count,
  output logic        sel_changed
);
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int DIV_W = $clog2(DIV);
  localparam int GC_W  = $clog2(GOOD_WINDOWS + 1);

  typedef enum logic [1:0] {ST_DIV, ST_QUAL, ST_EXT} state_t;

  logic [2:0]       sync_reg;
  logic             edge_det;
  logic [WIN_W-1:0] win_cnt_reg;
  logic             win_close;
  logic [15:0]      edge_cnt_reg;
  logic [15:0]      edge_sum;
  logic [15:0]      last_count_reg;
  logic             window_good;
  state_t           state_reg, state_next;
  logic [GC_W-1:0]  good_cnt_reg, good_cnt_next;
  logic [DIV_W-1:0] div_cnt_reg;
  logic             div_high, div_fall;
  logic             fast_clk_div_reg, fast_clk_sel_reg, sel_changed_reg;
  logic             sel_target, sel_pending;

  // sync_reg[1] is the second synchronizer stage, sync_reg[2] the edge-detect history.
  assign edge_det    = sync_reg[1] & ~sync_reg[2];
  assign edge_sum    = (edge_cnt_reg == 16'hFFFF) ? 16'hFFFF : edge_cnt_reg + {15'd0, edge_det};
  assign win_close   = (win_cnt_reg == WIN_W'(WINDOW - 1));
  assign window_good = (edge_sum >= 16'(MIN_EDGES)) && (edge_sum <= 16'(MAX_EDGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg       <= '0;
      win_cnt_reg    <= '0;
      edge_cnt_reg   <= '0;
      last_count_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], fast_clk_ext};
      if (win_close) begin
        win_cnt_reg    <= '0;
        edge_cnt_reg   <= '0;
        last_count_reg <= edge_sum;
      end else begin
        win_cnt_reg  <= win_cnt_reg + 1'b1;
        edge_cnt_reg <= edge_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_DIV;
      good_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    if (force_div) begin
      state_next    = ST_DIV;
      good_cnt_next = '0;
    end else if (win_close) begin
      case (state_reg)
        ST_DIV: begin
          if (window_good) begin
            if (GOOD_WINDOWS <= 1) begin
              state_next    = ST_EXT;
              good_cnt_next = '0;
            end else begin
              state_next    = ST_QUAL;
              good_cnt_next = GC_W'(1);
            end
          end
        end
        ST_QUAL: begin
          if (!window_good) begin
            state_next    = ST_DIV;
            good_cnt_next = '0;
          end else if (good_cnt_reg >= GC_W'(GOOD_WINDOWS - 1)) begin
            state_next    = ST_EXT;
            good_cnt_next = '0;
          end else begin
            good_cnt_next = good_cnt_reg + 1'b1;
          end
        end
        ST_EXT: begin
          if (!window_good) begin
            state_next    = ST_DIV;
            good_cnt_next = '0;
          end
        end
        default: begin
          state_next    = ST_DIV;
          good_cnt_next = '0;
        end
      endcase
    end
  end

  // div_fall marks the clock edge on which fast_clk_div drops from 1 to 0.
  assign div_high    = (div_cnt_reg < DIV_W'(DIV / 2));
  assign div_fall    = fast_clk_div_reg & ~div_high;
  assign sel_target  = (state_reg == ST_EXT);
  assign sel_pending = (sel_target != fast_clk_sel_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg      <= '0;
      fast_clk_div_reg <= 1'b0;
      fast_clk_sel_reg <= 1'b0;
      sel_changed_reg  <= 1'b0;
    end else begin
      div_cnt_reg      <= (div_cnt_reg == DIV_W'(DIV - 1)) ? '0 : div_cnt_reg + 1'b1;
      fast_clk_div_reg <= div_high;
      sel_changed_reg  <= 1'b0;
      if (div_fall && sel_pending) begin
        fast_clk_sel_reg <= sel_target;
        sel_changed_reg  <= 1'b1;
      end
    end
  end

  assign fast_clk_div = fast_clk_div_reg;
  assign fast_clk_sel = fast_clk_sel_reg;
  assign sel_changed  = sel_changed_reg;
  assign last_count   = last_count_reg;
  assign ext_ok       = (state_reg == ST_EXT);

endmodule
